// File: rtl/linear_layer_fifo_pkg.sv
// ---------------------------------------------------------------------------
// linear_layer_fifo_pkg
// Shared definitions for the Linear_Layer start-token FIFO slice:
//   - occ_width():          width of an occupancy count (ADDR_WIDTH + 1)
//   - fifo_params_legal():  DEPTH >= 2 and 2**ADDR_WIDTH >= DEPTH
//   - ERR_NONE / ERR_SEEN:  encoding of the err_sticky bit
// ---------------------------------------------------------------------------
package linear_layer_fifo_pkg;

  // Occupancy runs 0..DEPTH, and DEPTH can equal 2**ADDR_WIDTH, so one extra bit.
  function automatic int occ_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit fifo_params_legal(input int depth, input int addr_width);
    return (depth >= 2) && ((1 << addr_width) >= depth);
  endfunction

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SEEN = 1'b1;

endpackage

// File: rtl/linear_layer_start_token_srl.sv
// ---------------------------------------------------------------------------
// linear_layer_start_token_srl
// Pure storage for the start-token FIFO: a DEPTH x DATA_WIDTH shift register.
// Entry 0 always holds the newest token. The read is asynchronous.
// Ports:
//   clk   in   rising-edge clock
//   we    in   shift din into entry 0 (older entries move up one slot)
//   addr  in   ADDR_WIDTH read index
//   din   in   DATA_WIDTH write data
//   dout  out  DATA_WIDTH contents of entry addr
// Storage has no reset: its contents are only meaningful below the
// controller's occupancy count.
// ---------------------------------------------------------------------------
module linear_layer_start_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_token_fifo.sv
// ---------------------------------------------------------------------------
// linear_layer_start_token_fifo
// SRL-backed start-token FIFO between a producer process and a downstream PE
// process of the Linear_Layer_i4xi4_q kernel. This controller owns the
// full/empty flags, the occupancy count and the read address. Data lives only
// in linear_layer_start_token_srl.
//
// Handshake: a write transfers on an edge where if_write & if_write_ce &
// if_full_n are all high; a read transfers on an edge where if_read &
// if_read_ce & if_empty_n are all high. if_dout is show-ahead: it already
// holds the head token whenever if_empty_n is high. Requests without the
// matching flag are ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   if_write_ce/if_write/if_din   write side
//   if_full_n           high = space available (registered)
//   if_read_ce/if_read  read side
//   if_dout             oldest entry
//   if_empty_n          high = data available (registered)
//   if_num_data_valid   current occupancy
//   if_fifo_cap         constant DEPTH
//   err_sticky          only when LINEAR_LAYER_FIFO_ERR_CHECK_EN is defined:
//                       latches any overflow/underflow attempt until reset
// ---------------------------------------------------------------------------
module linear_layer_start_token_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
  ,
  output logic                  err_sticky
`endif
);

  localparam int            CW      = occ_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!fifo_params_legal(DEPTH, ADDR_WIDTH)) begin : g_bad_params
    $error("linear_layer_start_token_fifo: need DEPTH >= 2 and 2**ADDR_WIDTH >= DEPTH");
  end

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  empty_n_q;
  logic                  full_n_q;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + CW'(1);
    end else if (pop && !push) begin
      cnt_next = cnt - CW'(1);
    end
  end

  // Head sits at index cnt-1. Using the low bits wraps correctly when
  // cnt == 2**ADDR_WIDTH. On a simultaneous push+pop the shift moves the
  // next-oldest token into the unchanged head slot, so no special case.
  assign addr = (cnt != '0) ? (cnt[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) : '0;

  // Flags come from next-state so they are plain registers at the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      cnt       <= cnt_next;
      empty_n_q <= (cnt_next != '0);
      full_n_q  <= (cnt_next != DEPTH_C);
    end
  end

  linear_layer_start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .addr (addr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = DEPTH_C;

`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= ERR_NONE;
    end else if ((if_write && if_write_ce && !full_n_q) ||
                 (if_read  && if_read_ce  && !empty_n_q)) begin
      err_q <= ERR_SEEN;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
// ---------------------------------------------------------------------------
// tb_linear_layer_start_token_fifo
// Directed bench for linear_layer_start_token_fifo (DEPTH=3, ADDR_WIDTH=2,
// DATA_WIDTH=1). The driver pushes each accepted token onto exp_q; a monitor
// on the falling edge pops and compares whenever the DUT presents a token
// that is being read. Flag/occupancy values are hand-computed constants.
// Build with LINEAR_LAYER_FIFO_ERR_CHECK_EN to also cover err_sticky.
// ---------------------------------------------------------------------------
module tb_linear_layer_start_token_fifo;

  localparam int DW = 1;
  localparam int AW = 2;
  localparam int DP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          if_write_ce = 1'b0;
  logic          if_write    = 1'b0;
  logic [DW-1:0] if_din      = '0;
  logic          if_full_n;
  logic          if_read_ce  = 1'b0;
  logic          if_read     = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;
`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
  logic          err_sticky;
`endif

  linear_layer_start_token_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_full_n         (if_full_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_empty_n        (if_empty_n),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap)
`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
    ,
    .err_sticky        (err_sticky)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a read is being taken on the coming edge whenever the DUT says
  // data is available and the read side is enabled.
  always @(negedge clk) begin
    if (!reset && if_read && if_read_ce && if_empty_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dout_unexpected: got %0d expected no token", if_dout);
      end else begin
        check("dout", 32'(if_dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus; inputs change 1ns after the rising edge and
  // outputs are sampled there too, well away from the next edge.
  task automatic step(input logic w, input logic wce, input logic [DW-1:0] d,
                      input logic r, input logic rce, input logic rst);
    logic mpush;
    logic mpop;
    mpush = !rst && w && wce && (model_cnt < DP);
    mpop  = !rst && r && rce && (model_cnt > 0);
    reset       = rst;
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (mpush) exp_q.push_back(d);
      model_cnt = model_cnt + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    check("rst_empty_n", 32'(if_empty_n), 0);
    check("rst_full_n", 32'(if_full_n), 1);
    check("rst_count", 32'(if_num_data_valid), 0);
    check("fifo_cap", 32'(if_fifo_cap), 3);
`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
    check("rst_err", 32'(err_sticky), 0);
`endif

    // Fill: 1, 0, 1 then an ignored 4th push.
    wr(1'b1);
    check("fill1_empty_n", 32'(if_empty_n), 1);
    check("fill1_dout", 32'(if_dout), 1);
    check("fill1_count", 32'(if_num_data_valid), 1);
    wr(1'b0);
    check("fill2_full_n", 32'(if_full_n), 1);
    wr(1'b1);
    check("full_full_n", 32'(if_full_n), 0);
    check("full_dout", 32'(if_dout), 1);
    check("full_count", 32'(if_num_data_valid), 3);
    wr(1'b0);
    check("ovf_count", 32'(if_num_data_valid), 3);
    check("ovf_full_n", 32'(if_full_n), 0);
    check("ovf_dout", 32'(if_dout), 1);

    // Drain: monitor expects 1, 0, 1.
    rd();
    check("pop1_full_n", 32'(if_full_n), 1);
    check("pop1_count", 32'(if_num_data_valid), 2);
    rd();
    rd();
    check("drain_empty_n", 32'(if_empty_n), 0);
    check("drain_count", 32'(if_num_data_valid), 0);

    // Streaming at cnt=1: head 0, then push+pop with alternating data.
    wr(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, DW'(i % 2 == 0), 1'b1, 1'b1, 1'b0);
      check("stream_count", 32'(if_num_data_valid), 1);
      check("stream_dout", 32'(if_dout), 32'(i % 2 == 0));
      check("stream_empty_n", 32'(if_empty_n), 1);
    end
    rd();
    check("stream_drain_count", 32'(if_num_data_valid), 0);

    // Reset wins over a same-cycle push and pop.
    wr(1'b1);
    wr(1'b0);
    check("pre_rst_count", 32'(if_num_data_valid), 2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_count", 32'(if_num_data_valid), 0);
    check("midrst_empty_n", 32'(if_empty_n), 0);
    check("midrst_full_n", 32'(if_full_n), 1);
    idle();

    // Clock-enable freezes: write with ce low, then read with ce low.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("wce_freeze_count", 32'(if_num_data_valid), 0);
    check("wce_freeze_empty_n", 32'(if_empty_n), 0);
    wr(1'b1);
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    check("rce_freeze_count", 32'(if_num_data_valid), 1);
    check("rce_freeze_dout", 32'(if_dout), 1);
    rd();

    // Underflow attempt is ignored (and latched when error checking is on).
    rd();
    check("unf_count", 32'(if_num_data_valid), 0);
    check("unf_empty_n", 32'(if_empty_n), 0);
`ifdef LINEAR_LAYER_FIFO_ERR_CHECK_EN
    check("err_set", 32'(err_sticky), 1);
    wr(1'b0);
    rd();
    check("err_hold", 32'(err_sticky), 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("err_clear", 32'(err_sticky), 0);
    idle();
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linear_layer_start_token_fifo.md
# linear_layer_start_token_fifo

SRL-backed start-token FIFO that passes dataflow start tokens from a producer process to a downstream PE process (e.g. a PE_i4xi4 instance) inside the Linear_Layer_i4xi4_q kernel. The block owns the full/empty handshake, occupancy counting and read-address generation. It drives a separate shift-register storage sub-module, which holds the data. A write is one upstream start, and a read is one downstream start consumed.

## Interface
Parameters:
- DATA_WIDTH, 1, token payload width.
- ADDR_WIDTH, 2, read-address width into storage. Requires 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 3, entry count. Requires DEPTH >= 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  oldest entry (show-ahead).
- if_empty_n  out  1  high = data available.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

## Operation
- push = if_write & if_write_ce & if_full_n.
- pop = if_read & if_read_ce & if_empty_n.
- Requests made while full (write) or empty (read) are ignored and have no state effect.
- cnt register, range 0..DEPTH. It updates as follows:
  - push & !pop: cnt + 1.
  - pop & !push: cnt − 1.
  - push & pop, or neither: unchanged.
- Storage shifts in if_din on push (we = push). Index 0 is always the newest entry.
- Read address = cnt − 1 when cnt > 0, else 0. if_dout = storage[addr].
- When push and pop occur together, the shift pushes the oldest entry out of the window, and the next-oldest entry lands at the unchanged address. No special case is needed.
- if_empty_n and if_full_n are registered from next-state values:
  - if_empty_n <= (cnt_next != 0).
  - if_full_n <= (cnt_next != DEPTH).
- if_num_data_valid = cnt.
- Reset values:
  - cnt = 0, if_empty_n = 0, if_full_n = 1, if_num_data_valid = 0.
  - if_dout is undefined and storage is not cleared.
- Reset asserted mid-operation discards all entries on that edge. Reset has priority over a same-cycle push or pop.

## Timing
- Write-to-read latency is 1 cycle. A token pushed at edge N appears on if_dout with if_empty_n = 1 after edge N.
- A pop at edge N exposes the next entry after edge N. There is no bubble.
- if_full_n deasserts in the cycle after the push that reaches DEPTH. A pop while full reasserts it after the same edge.
- Full throughput: one push and one pop per cycle are sustained at any 0 < cnt < DEPTH.
- if_write_ce = 0 or if_read_ce = 0 freezes the corresponding side entirely, including any flag change caused by that side.

## Configuration
- LINEAR_LAYER_FIFO_ERR_CHECK_EN
  - Defined: adds output err_sticky (1 bit, reset 0). It sets and holds on any cycle with if_write & if_write_ce & !if_full_n (overflow attempt) or if_read & if_read_ce & !if_empty_n (underflow attempt). Only reset clears it.
  - Undefined: the port and its logic are absent. Illegal requests are silently ignored as described above.

## Structure
- Shared package linear_layer_fifo_pkg holds:
  - occupancy-width helper constant/function (ADDR_WIDTH+1);
  - parameter legality checks (DEPTH >= 2, 2**ADDR_WIDTH >= DEPTH);
  - err_sticky bit encoding.
- One sub-module: linear_layer_start_token_srl.
  - Pure storage: DEPTH×DATA_WIDTH shift register.
  - Ports: we, addr, din, dout.
  - Asynchronous read: dout = SRL[addr].
- The controller contains no data storage of its own.

## Test plan
- Reset, then idle 5 cycles -> if_empty_n = 0, if_full_n = 1, if_num_data_valid = 0, if_fifo_cap = 3.
- Push 1, 0, 1 on consecutive cycles with DEPTH = 3 -> if_full_n = 0 after the third edge; dout = 1 (first token); a 4th push is ignored and cnt stays 3.
- From full, pop three times -> dout sequence 1, 0, 1; if_empty_n = 0 after the third edge; if_full_n = 1 after the first pop.
- cnt = 1 with head value 0, push 1 and pop simultaneously for 4 cycles with alternating data -> cnt stays 1 and dout tracks each prior-cycle din with no gaps.
- Fill to 2, then assert reset together with push & pop -> cnt = 0, if_empty_n = 0, if_full_n = 1 on the next cycle.
- With LINEAR_LAYER_FIFO_ERR_CHECK_EN defined, a read request when empty -> err_sticky = 1 next cycle, it holds through later legal traffic, and reset clears it.
